// File: rtl/mem_access_bridge_pkg.sv
// Shared encodings for the memory access bridge: RV32 load/store func3 codes,
// bridge FSM states, byte-enable masks and the access legality rule.
package mem_access_bridge_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Unsigned loads exist only on the load side; half/word need natural alignment.
  function automatic logic access_ok(input logic we, input logic [2:0] func3,
                                     input logic [1:0] off);
    logic ok;
    case (func3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~off[0];
      F3_LW:   ok = (off == 2'b00);
      F3_LBU:  ok = ~we;
      F3_LHU:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_bridge_if.sv
// External memory bus of the bridge: req/ack handshake with word address,
// lane-shifted write data, byte enables and read data.
interface mem_access_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_bridge_load_extender.sv
// Selects the addressed byte/halfword of a bus read word and sign- or
// zero-extends it according to the RV32 load func3.
module mem_access_bridge_load_extender
  import mem_access_bridge_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select by byte offset, then width/sign extension.
  always_comb begin
    case (offset_i)
      2'b00:   byte_s = word_i[7:0];
      2'b01:   byte_s = word_i[15:8];
      2'b10:   byte_s = word_i[23:16];
      2'b11:   byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (func3_i)
      F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
      F3_LH:   data_o = {{16{half_s[15]}}, half_s};
      F3_LW:   data_o = word_i;
      F3_LBU:  data_o = {24'h000000, byte_s};
      F3_LHU:  data_o = {16'h0000, half_s};
      default: data_o = 32'h00000000;
    endcase
  end

endmodule

// File: rtl/mem_access_bridge.sv
// Turns single-request core loads/stores into req/ack bus transactions, stalling
// the core until done. Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT cycles.
module mem_access_bridge
  import mem_access_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_func3_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_stall_o,
  output logic              core_err_o,
  mem_access_bridge_if.master bus
);

  state_e            state_q;
  logic [2:0]        func3_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [3:0]        bus_be_q;

  logic [1:0]        off_s;
  logic              legal_s;
  logic [3:0]        be_s;
  logic [DATA_W-1:0] wdata_s;
  logic [31:0]       ext_s;
  logic              stall_s;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
`else
  logic timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT != 0);
`endif

  assign off_s   = core_addr_i[1:0];
  assign legal_s = access_ok(core_we_i, core_func3_i, off_s);

  // Byte enables and lane replication so any enabled lane carries the store data.
  always_comb begin
    case (core_func3_i[1:0])
      2'b00: begin
        be_s    = BE_BYTE << off_s;
        wdata_s = {4{core_wdata_i[7:0]}};
      end
      2'b01: begin
        be_s    = BE_HALF << off_s;
        wdata_s = {2{core_wdata_i[15:0]}};
      end
      2'b10: begin
        be_s    = BE_WORD;
        wdata_s = core_wdata_i;
      end
      default: begin
        be_s    = BE_NONE;
        wdata_s = {DATA_W{1'b0}};
      end
    endcase
  end

  mem_access_bridge_load_extender u_load_extender (
    .func3_i  (func3_q),
    .offset_i (off_q),
    .word_i   (bus.bus_rdata),
    .data_o   (ext_s)
  );

  // Stall follows the request in IDLE so the controller freezes in the request cycle.
  always_comb begin
    case (state_q)
      ST_IDLE: stall_s = core_req_i;
      ST_BUSY: stall_s = 1'b1;
      default: stall_s = 1'b0;
    endcase
  end

  // Bridge FSM with all bus and core results held in registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      func3_q     <= 3'b000;
      off_q       <= 2'b00;
      we_q        <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      err_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_wdata_q <= {DATA_W{1'b0}};
      bus_be_q    <= 4'b0000;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (core_req_i) begin
            func3_q <= core_func3_i;
            off_q   <= off_s;
            we_q    <= core_we_i;
            if (legal_s) begin
              state_q     <= ST_BUSY;
              bus_req_q   <= 1'b1;
              bus_we_q    <= core_we_i;
              bus_addr_q  <= {core_addr_i[ADDR_W-1:2], 2'b00};
              bus_wdata_q <= wdata_s;
              bus_be_q    <= be_s;
`ifdef MEM_TIMEOUT_EN
              cnt_q       <= {CNT_W{1'b0}};
`endif
            end else begin
              state_q <= ST_DONE;
              err_q   <= 1'b1;
              rdata_q <= {DATA_W{1'b0}};
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (bus.bus_ack) begin
            state_q   <= ST_DONE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b0;
            if (we_q) begin
              rdata_q <= {DATA_W{1'b0}};
            end else begin
              rdata_q <= ext_s;
            end
          end
`ifdef MEM_TIMEOUT_EN
          // An ack in the limit cycle is taken above, so it completes normally.
          else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q   <= ST_DONE;
            bus_req_q <= 1'b0;
            err_q     <= 1'b1;
            rdata_q   <= {DATA_W{1'b0}};
          end else begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          else begin
            state_q <= ST_BUSY;
          end
`endif
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_stall_o  = stall_s;
  assign core_rdata_o  = rdata_q;
  assign core_err_o    = err_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.bus_be    = bus_be_q;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Scoreboard bench for mem_access_bridge: random and directed accesses against a
// reference model; a bus responder with random ack latency and stray acks.
module tb_mem_access_bridge;

`ifdef MEM_TIMEOUT_EN
  localparam int  TB_TO = 4;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  TB_TO = 255;
  localparam bit  TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } done_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_func3;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        core_err;

  int          checks;
  int          errors;
  int          ack_delay;
  logic [31:0] cur_rword;
  bit          force_ack;
  done_t       done_q[$];
  bus_t        bus_q[$];

  mem_access_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_func3_i (core_func3),
    .core_addr_i  (core_addr),
    .core_wdata_i (core_wdata),
    .core_rdata_o (core_rdata),
    .core_stall_o (core_stall),
    .core_err_o   (core_err),
    .bus          (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input int f3);
    return 1 << (f3 % 4);
  endfunction

  function automatic bit m_legal(input bit we, input int f3, input int off);
    if (f3 == 3 || f3 >= 6) return 1'b0;
    if (we && f3 >= 4) return 1'b0;
    return (off % m_size(f3)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input int off, input logic [31:0] w);
    logic [31:0] s;
    int v;
    s = w >> (8 * off);
    case (f3)
      0: begin v = int'(s[7:0]);  if (v >= 128)   v -= 256;   return 32'(v); end
      1: begin v = int'(s[15:0]); if (v >= 32768) v -= 65536; return 32'(v); end
      2: return w;
      4: return 32'(s[7:0]);
      5: return 32'(s[15:0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input int f3, input int off);
    int m;
    m = ((1 << m_size(f3)) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] w);
    case (f3 % 4)
      0: return 32'(w[7:0]) * 32'h01010101;
      1: return 32'(w[15:0]) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  // ---------------- bus responder ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = $urandom;
      end else if (bus_if.bus_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          bus_if.bus_ack   = 1'b1;
          bus_if.bus_rdata = cur_rword;
        end else begin
          bus_if.bus_ack   = 1'b0;
          bus_if.bus_rdata = $urandom;
          wait_cnt++;
        end
      end else begin
        bus_if.bus_ack   = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = $urandom;
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && core_req === 1'b1 && core_stall === 1'b0) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got DONE with rdata 0x%08h expected none", core_rdata);
        end else begin
          e = done_q.pop_front();
          check("core_rdata", core_rdata, e.rdata);
          check("core_err", 32'(core_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    bus_t b;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req === 1'b1 && !prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_req_unexpected: got bus_req addr 0x%08h expected none", bus_if.bus_addr);
        end else begin
          b = bus_q.pop_front();
          check("bus_addr", bus_if.bus_addr, b.addr);
          check("bus_we", 32'(bus_if.bus_we), 32'(b.we));
          if (b.we) begin
            check("bus_be", 32'(bus_if.bus_be), 32'(b.be));
            check("bus_wdata", bus_if.bus_wdata, b.wdata);
          end
        end
      end
      prev = (bus_if.bus_req === 1'b1);
    end
  end

  // ---------------- driver ----------------
  // Called and returns at posedge+1; leaves core_req high so the caller can go back-to-back.
  task automatic do_access(input bit we, input int f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword, input int delay);
    int  off;
    bit  legal;
    bit  timed_out;
    int  stalls;
    int  exp_stalls;
    bit  done;
    off       = int'(addr[1:0]);
    legal     = m_legal(we, f3, off);
    timed_out = legal && TO_EN && (delay >= TB_TO);
    if (legal) begin
      bus_q.push_back('{addr: {addr[31:2], 2'b00}, we: we, be: m_be(f3, off),
                        wdata: m_wdata(f3, wdata)});
      if (timed_out) done_q.push_back('{rdata: 32'h0, err: 1'b1});
      else done_q.push_back('{rdata: (we ? 32'h0 : m_load(f3, off, rword)), err: 1'b0});
      exp_stalls = timed_out ? TB_TO + 1 : delay + 2;
    end else begin
      done_q.push_back('{rdata: 32'h0, err: 1'b1});
      exp_stalls = 1;
    end
    core_we    = we;
    core_func3 = 3'(f3);
    core_addr  = addr;
    core_wdata = wdata;
    cur_rword  = rword;
    ack_delay  = delay;
    core_req   = 1'b1;
    stalls     = 0;
    done       = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (core_stall === 1'b1) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE within 400 cycles expected DONE");
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic idle_cycle();
    core_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    force_ack  = 1'b0;
    ack_delay  = 0;
    cur_rword  = 32'h0;
    rst        = 1'b1;
    core_req   = 1'b0;
    core_we    = 1'b0;
    core_func3 = 3'b000;
    core_addr  = 32'h0;
    core_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", 32'(bus_if.bus_req), 32'h0);
    check("rst_bus_we", 32'(bus_if.bus_we), 32'h0);
    check("rst_bus_addr", bus_if.bus_addr, 32'h0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    check("rst_bus_be", 32'(bus_if.bus_be), 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_core_err", 32'(core_err), 32'h0);
    check("rst_core_stall", 32'(core_stall), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // directed cases
    do_access(1'b1, 2, 32'h00000100, 32'hDEADBEEF, 32'h0, 1);
    idle_cycle();
    do_access(1'b1, 0, 32'h00000203, 32'h000000A5, 32'h0, 0);
    do_access(1'b0, 0, 32'h00000302, 32'h0, 32'h11803344, 0);
    do_access(1'b0, 4, 32'h00000302, 32'h0, 32'h11803344, 2);
    do_access(1'b0, 5, 32'h00000302, 32'h0, 32'h11803344, 3);
    do_access(1'b0, 1, 32'h00000302, 32'h0, 32'h11803344, 0);
    do_access(1'b0, 2, 32'h00000401, 32'h0, 32'h12345678, 0);
    idle_cycle();
    do_access(1'b1, 1, 32'h00000101, 32'h0000BEEF, 32'h0, 0);
    do_access(1'b1, 1, 32'h00000102, 32'h0000BEEF, 32'h0, 0);
    do_access(1'b0, 3, 32'h00000100, 32'h0, 32'h0, 0);
    do_access(1'b1, 4, 32'h00000100, 32'h0, 32'h0, 0);
    do_access(1'b0, 7, 32'h00000100, 32'h0, 32'h0, 0);
    do_access(1'b0, 5, 32'h00000103, 32'h0, 32'h0, 0);
    idle_cycle();

    // randomized accesses, biased toward legal func3 codes
    for (int n = 0; n < 200; n++) begin
      bit          we;
      int          f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) begin
        f3 = we ? $urandom_range(0, 2) : $urandom_range(0, 5);
        if (f3 == 3) f3 = 4;
      end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(m_size(f3)) - 32'h1);
      do_access(we, f3, addr, $urandom, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

`ifdef MEM_TIMEOUT_EN
    do_access(1'b0, 2, 32'h00000500, 32'h0, 32'hCAFEF00D, 1000);
    do_access(1'b1, 2, 32'h00000504, 32'h01020304, 32'h0, TB_TO - 1);
    idle_cycle();
`endif

    // reset in the middle of BUSY, with acks presented during and after it
    bus_q.push_back('{addr: 32'h00000600, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    core_we    = 1'b0;
    core_func3 = 3'b010;
    core_addr  = 32'h00000600;
    ack_delay  = 1000;
    core_req   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    check("busy_before_rst", 32'(bus_if.bus_req), 32'h1);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    core_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_mid_busy_bus_req", 32'(bus_if.bus_req), 32'h0);
      check("rst_mid_busy_stall", 32'(core_stall), 32'h0);
      check("rst_mid_busy_err", 32'(core_err), 32'h0);
    end
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    do_access(1'b0, 0, 32'h00000701, 32'h0, 32'h0000FF00, 1);
    idle_cycle();
    repeat (4) @(posedge clk);
    #1;

    check("done_queue_empty", 32'(done_q.size()), 32'h0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
